// File: rtl/gpio_in_cntl_if.sv
// Core data-port bus as seen by the GPIO input block: address, store data/strobe, load data.
interface gpio_in_cntl_if;
  logic [31:0] dataaddress;
  logic [31:0] writedata;
  logic        wenable;
  logic [31:0] readdata;

  modport master (output dataaddress, output writedata, output wenable, input readdata);
  modport slave  (input dataaddress, input writedata, input wenable, output readdata);
endinterface

// File: rtl/gpio_in_cntl.sv
// Memory-mapped GPIO input port: per-pin synchroniser + debouncer, sticky W1C
// edge flags, per-bit interrupt enables and a registered level interrupt.
module gpio_in_cntl #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_8010,
  parameter int          DB_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  gpio_in_cntl_if.slave        bus,
  input  logic [WIDTH-1:0]     pins,
  output logic                 irq
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] irqen_q, irqen_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] rise_p, fall_p;
  logic [WIDTH-1:0] rise_clr, fall_clr;
  logic             sel, wr;
  logic [1:0]       reg_idx;
  logic             unused_ok;

  assign sel       = (bus.dataaddress[31:4] == BASE_ADDR[31:4]);
  assign reg_idx   = bus.dataaddress[3:2];
  assign wr        = sel && bus.wenable;
  assign unused_ok = ^{bus.dataaddress[1:0], bus.writedata};

  always_comb begin
    s1_d   = pins;
    s2_d   = s1_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    rise_p = '0;
    fall_p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i]  = s2_q[i];
        cnt_d[i]  = '0;
        rise_p[i] = s2_q[i];
        fall_p[i] = ~s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rise_clr = (wr && reg_idx == 2'd1) ? bus.writedata[WIDTH-1:0] : '0;
    fall_clr = (wr && reg_idx == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;
    irqen_d  = (wr && reg_idx == 2'd3) ? bus.writedata[WIDTH-1:0] : irqen_q;
    // OR-ing the pulse in after the clear means a new event always survives
    rise_d   = (rise_q & ~rise_clr) | rise_p;
    fall_d   = (fall_q & ~fall_clr) | fall_p;
    irq_d    = |((rise_q | fall_q) & irqen_q);
    readdata_d = 32'b0;
    if (sel) begin
      case (reg_idx)
        2'd0:    readdata_d = 32'(deb_q);
        2'd1:    readdata_d = 32'(rise_q);
        2'd2:    readdata_d = 32'(fall_q);
        default: readdata_d = 32'(irqen_q);
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
      irqen_q    <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      irqen_q    <= irqen_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_gpio_in_cntl.sv
// Directed bench for gpio_in_cntl: register-access vector table plus timed
// debounce, glitch, interrupt, set-beats-clear and reset-mid-debounce sequences.
module tb_gpio_in_cntl;
  localparam logic [31:0] BASE = 32'h0000_8010;
  localparam int          DB   = 16;

  logic       clk;
  logic       rst;
  logic [7:0] pins;
  logic       irq;
  int         total;
  int         bad;

  gpio_in_cntl_if bus ();

  gpio_in_cntl #(.WIDTH(8), .BASE_ADDR(BASE), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus),
    .pins  (pins),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [16];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic wen);
    bus.dataaddress = addr;
    bus.writedata   = wdata;
    bus.wenable     = wen;
  endtask

  task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] exp);
    drive(addr, 32'h0, 1'b0);
    cyc();
    chk(name, bus.readdata, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    drive(addr, data, 1'b1);
    cyc();
    drive(addr, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    pins  = 8'h00;
    rst   = 1'b1;
    drive(BASE, 32'h0, 1'b0);

    // Register access vectors, starting from DATA=05 RISE=05 FALL=00 IRQEN=00.
    // Expected readdata on a write is the pre-write value (read and write share the edge).
    vecs[0]  = '{BASE + 32'h0,  32'h0,         1'b0, 32'h05, 1'b0};
    vecs[1]  = '{BASE + 32'h4,  32'h0,         1'b0, 32'h05, 1'b0};
    vecs[2]  = '{BASE + 32'h8,  32'h0,         1'b0, 32'h00, 1'b0};
    vecs[3]  = '{BASE + 32'hC,  32'h0,         1'b0, 32'h00, 1'b0};
    vecs[4]  = '{BASE + 32'hC,  32'hFFFF_FF03, 1'b1, 32'h00, 1'b0};
    vecs[5]  = '{BASE + 32'hC,  32'h0,         1'b0, 32'h03, 1'b1};
    vecs[6]  = '{BASE + 32'h0,  32'hFF,        1'b1, 32'h05, 1'b1};
    vecs[7]  = '{BASE + 32'h0,  32'h0,         1'b0, 32'h05, 1'b1};
    vecs[8]  = '{BASE + 32'h4,  32'h1,         1'b1, 32'h05, 1'b1};
    vecs[9]  = '{BASE + 32'h4,  32'h0,         1'b0, 32'h04, 1'b0};
    vecs[10] = '{BASE + 32'h20, 32'h0,         1'b0, 32'h00, 1'b0};
    vecs[11] = '{32'h0,         32'h0,         1'b0, 32'h00, 1'b0};
    vecs[12] = '{BASE + 32'h1,  32'h0,         1'b0, 32'h05, 1'b0};
    vecs[13] = '{BASE + 32'hC,  32'h0,         1'b1, 32'h03, 1'b0};
    vecs[14] = '{BASE + 32'h4,  32'hFFFF_FFFF, 1'b1, 32'h04, 1'b0};
    vecs[15] = '{BASE + 32'h4,  32'h0,         1'b0, 32'h00, 1'b0};

    // 1: reset state
    idle(2);
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    rd("reset_data",  BASE + 32'h0, 32'h0);
    rd("reset_rise",  BASE + 32'h4, 32'h0);
    rd("reset_fall",  BASE + 32'h8, 32'h0);
    rd("reset_irqen", BASE + 32'hC, 32'h0);

    // 2: debounce latency; deb updates at edge 18, readdata shows it at edge 19
    drive(BASE, 32'h0, 1'b0);
    pins = 8'h05;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk($sformatf("latency_edge%0d", k), bus.readdata, (k >= 19) ? 32'h05 : 32'h00);
    end
    rd("rise_after_05", BASE + 32'h4, 32'h05);
    rd("fall_after_05", BASE + 32'h8, 32'h00);

    // Register access table
    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].wen);
      cyc();
      chk($sformatf("vec%0d_rd", i), bus.readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end
    drive(BASE, 32'h0, 1'b0);

    // 3: 10-cycle glitch on pin1 is never accepted
    pins = 8'h07;
    idle(10);
    pins = 8'h05;
    idle(25);
    rd("glitch_data", BASE + 32'h0, 32'h05);
    rd("glitch_rise", BASE + 32'h4, 32'h00);
    rd("glitch_fall", BASE + 32'h8, 32'h00);
    chk("glitch_irq", {31'b0, irq}, 32'h0);

    // 4: enabled rise raises irq one cycle after the flag; W1C drops it
    wr(BASE + 32'hC, 32'h02);
    pins = 8'h07;
    drive(BASE + 32'h4, 32'h0, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      cyc();
      if (k == 18) chk("irq_before", {31'b0, irq}, 32'h0);
      if (k == 19) begin
        chk("irq_after_rise", {31'b0, irq}, 32'h1);
        chk("rise_bit1", bus.readdata, 32'h02);
      end
    end
    wr(BASE + 32'h4, 32'h02);
    chk("irq_clear_edge", {31'b0, irq}, 32'h1);
    cyc();
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    rd("rise_cleared", BASE + 32'h4, 32'h00);
    wr(BASE + 32'hC, 32'h00);

    // 5: W1C on RISE[2] in the same cycle as bit 2's rise pulse
    pins = 8'h03;
    idle(22);
    rd("fall_bit2", BASE + 32'h8, 32'h04);
    wr(BASE + 32'h8, 32'hFF);
    drive(BASE + 32'h4, 32'h0, 1'b0);
    pins = 8'h07;
    for (int k = 1; k <= 19; k++) begin
      if (k == 18) drive(BASE + 32'h4, 32'h04, 1'b1);
      else         drive(BASE + 32'h4, 32'h00, 1'b0);
      cyc();
    end
    chk("set_beats_clear", bus.readdata, 32'h04);
    rd("fall_after_clear", BASE + 32'h8, 32'h00);

    // 6: reset with bit 4's counter at 9 discards it; full debounce restarts after release
    drive(BASE, 32'h0, 1'b0);
    pins = 8'h17;
    idle(11);
    rst = 1'b1;
    #1;
    chk("midrst_readdata", bus.readdata, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    idle(2);
    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      cyc();
      if (k >= 9) chk($sformatf("midrst_edge%0d", k), bus.readdata, (k >= 19) ? 32'h17 : 32'h00);
    end
    rd("midrst_fall", BASE + 32'h8, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
